mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 16 +
 rtl/word_ram.sv | 22 ++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
// Holds the FSM state enum, default sizing and counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_STATES = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/word_ram.sv
// Single-port word store: synchronous write, combinational read.
// Ports: clk, we, addr (word index), wdata in; rdata out.
module word_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one word access, acks later.
// Ports: Clk, reset, req, Address, wr, Datain in; Dataout, ack, misalign, busy out.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] Address,
  input  logic        wr,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        ack,
  output logic        misalign,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dout_q;
  logic [31:0]       rdata;
  logic              unused_addr;

  // Upper address bits wrap the space.
  assign unused_addr = ^Address[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (Address[1:0] != 2'b00) begin
            state_d = ERR;
          end else begin
            idx_d   = Address[AW+1:2];
            wr_d    = wr;
            wdata_d = Datain;
            cnt_d   = CNT_W'(WAIT_STATES);
            state_d = (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      dout_q  <= Dataout;
    end
  end

  word_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (Clk),
    .we    ((state_q == RESP) && wr_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Read data shows only in a read ack; otherwise the last value holds.
  always_comb begin
    Dataout = dout_q;
    if ((state_q == RESP) && !wr_q) Dataout = rdata;
    if (state_q == ERR) Dataout = '0;
  end

  assign ack      = (state_q == RESP) || (state_q == ERR);
  assign misalign = (state_q == ERR);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_STATES=2 and =0 instances.
// Drives after posedge+1, samples at the same point.
module tb_mem_responder;

  logic        Clk = 1'b0;
  logic        reset;
  logic        req  [2];
  logic [31:0] addr [2];
  logic        wr   [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        ack  [2];
  logic        mis  [2];
  logic        busy [2];

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_a (
    .Clk(Clk), .reset(reset), .req(req[0]), .Address(addr[0]),
    .wr(wr[0]), .Datain(din[0]), .Dataout(dout[0]), .ack(ack[0]),
    .misalign(mis[0]), .busy(busy[0])
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_b (
    .Clk(Clk), .reset(reset), .req(req[1]), .Address(addr[1]),
    .wr(wr[1]), .Datain(din[1]), .Dataout(dout[1]), .ack(ack[1]),
    .misalign(mis[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One transaction; inputs are scrambled while busy to prove latching.
  task automatic txn(input int u, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output int lat,
                     output logic [31:0] q);
    req[u] = 1'b1; wr[u] = w; addr[u] = a; din[u] = d;
    tick();
    req[u] = 1'b0; wr[u] = ~w; addr[u] = ~a; din[u] = ~d;
    lat = 1;
    while (!ack[u] && lat < 20) begin
      tick();
      lat++;
    end
    q = dout[u];
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [31:0] q;
    bit          seen;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; din[u] = '0;
    end
    reset = 1'b1;
    tick();
    tick();
    chk("rst_ack_a",  32'(ack[0]),  32'd0);
    chk("rst_busy_a", 32'(busy[0]), 32'd0);
    chk("rst_mis_a",  32'(mis[0]),  32'd0);
    chk("rst_dout_a", dout[0],      32'd0);
    chk("rst_busy_b", 32'(busy[1]), 32'd0);
    chk("rst_dout_b", dout[1],      32'd0);
    reset = 1'b0;
    tick();

    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, q);
    chk("wr10_lat", lat, 32'd3);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, lat, q);
    chk("rd10_lat", lat, 32'd3);
    chk("rd10_data", q, 32'hDEAD_BEEF);
    chk("rd10_hold", dout[0], 32'hDEAD_BEEF);
    chk("rd10_ackoff", 32'(ack[0]), 32'd0);

    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0402;
    tick();
    chk("err_ack",  32'(ack[0]),  32'd1);
    chk("err_mis",  32'(mis[0]),  32'd1);
    chk("err_dout", dout[0],      32'd0);
    chk("err_busy", 32'(busy[0]), 32'd1);
    req[0] = 1'b0;
    tick();
    chk("post_err_ack",  32'(ack[0]),  32'd0);
    chk("post_err_mis",  32'(mis[0]),  32'd0);
    chk("post_err_busy", 32'(busy[0]), 32'd0);
    chk("post_err_dout", dout[0],      32'd0);

    txn(0, 1'b1, 32'h0000_0012, 32'hFFFF_FFFF, lat, q);
    chk("errwr_lat", lat, 32'd1);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, lat, q);
    chk("errwr_nochange", q, 32'hDEAD_BEEF);

    txn(0, 1'b1, 32'h0000_0404, 32'h1234_5678, lat, q);
    txn(0, 1'b0, 32'h0000_0004, 32'h0, lat, q);
    chk("wrap_data", q, 32'h1234_5678);
    chk("wrap_lat", lat, 32'd3);

    txn(0, 1'b1, 32'h0000_0020, 32'h1111_2222, lat, q);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'h3333_4444;
    tick();
    req[0] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_ack",  32'(ack[0]),  32'd0);
    chk("abort_dout", dout[0],      32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ack[0]) seen = 1'b1;
      tick();
    end
    chk("abort_noack", 32'(seen), 32'd0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, lat, q);
    chk("abort_old", q, 32'h1111_2222);

    txn(1, 1'b1, 32'h0000_0008, 32'hA5A5_0F0F, lat, q);
    chk("b_wr_lat", lat, 32'd1);
    txn(1, 1'b0, 32'h0000_0008, 32'h0, lat, q);
    chk("b_rd_lat", lat, 32'd1);
    chk("b_rd_data", q, 32'hA5A5_0F0F);

    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0000_0008;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b_ack_%0d", i), 32'(ack[1]), 32'(i % 2));
      chk($sformatf("b_busy_%0d", i), 32'(busy[1]), 32'(i % 2));
      if (i % 2 == 1) chk($sformatf("b_dout_%0d", i), dout[1], 32'hA5A5_0F0F);
      tick();
    end
    req[1] = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
